mac_stream_accum: RTL and testbench

MAC_STREAM_ACCUM -- requirements
Module: mac_stream_accum

---
 rtl/mac_stream_pkg.sv | 17 +
 rtl/mac_mult_stage.sv | 62 ++++++
 rtl/mac_stream_accum.sv | 148 ++++++++++++++
 tb/tb_mac_stream_accum.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mac_stream_pkg.sv
// mac_stream_pkg
//   Shared definitions for the streaming multiply-accumulate block:
//   FSM state encoding and default parameter values.
package mac_stream_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_e;

  localparam int DEF_IN_W    = 4;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_N_TERMS = 128;
  localparam int DEF_SIGNED  = 0;

endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage
//   Registered multiplier: one product per accepted beat, extended to the
//   accumulator width (zero-extended when SIGNED=0, sign-extended when 1).
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   en_i           : beat accepted this cycle
//   a_i, b_i       : operands
//   prod_valid_o   : prod_o holds a product to be accumulated
//   prod_o         : extended product, ACC_W bits
module mac_mult_stage
  import mac_stream_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SIGNED = DEF_SIGNED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  output logic              prod_valid_o,
  output logic [ACC_W-1:0]  prod_o
);

  localparam int PW = 2 * IN_W;

  logic            sx;
  logic [PW-1:0]   a_x;
  logic [PW-1:0]   b_x;
  logic [PW-1:0]   prod_w;
  logic [ACC_W-1:0] prod_ext;
  logic            prod_valid_q;
  logic [ACC_W-1:0] prod_q;

  // Widening both operands first means the low PW bits of an unsigned
  // multiply equal the signed product as well, so one multiplier serves both.
  assign sx     = (SIGNED != 0);
  assign a_x    = {{IN_W{sx & a_i[IN_W-1]}}, a_i};
  assign b_x    = {{IN_W{sx & b_i[IN_W-1]}}, b_i};
  assign prod_w = a_x * b_x;

  if (ACC_W > PW) begin : g_ext
    assign prod_ext = {{(ACC_W-PW){sx & prod_w[PW-1]}}, prod_w};
  end else begin : g_noext
    assign prod_ext = prod_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
    end else begin
      prod_valid_q <= en_i;
      if (en_i) prod_q <= prod_ext;
    end
  end

  assign prod_valid_o = prod_valid_q;
  assign prod_o       = prod_q;

endmodule

// File: rtl/mac_stream_accum.sv
// mac_stream_accum
//   Streaming MAC: accumulates in_a*in_b over a frame (ended by in_last or
//   the N_TERMS-th beat) and presents sum, beat count and sticky overflow.
//   Optional macro MAC_SATURATE_EN: clamp at the crossed bound instead of
//   wrapping; the overflow flag behaves the same either way.
// Ports
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last : operand stream
//   out_valid/out_ready/out_sum/out_count/out_ovf : result stream
//
// state    | meaning
// ST_ACCUM | accepting beats, in_ready=1
// ST_DRAIN | final product in flight to the accumulator
// ST_HOLD  | result presented, waiting for out_ready
module mac_stream_accum
  import mac_stream_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int SIGNED  = DEF_SIGNED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_a,
  input  logic [IN_W-1:0]              in_b,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic [$clog2(N_TERMS+1)-1:0] out_count,
  output logic                         out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS+1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  mac_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic             accept;
  logic             prod_valid;
  logic [ACC_W-1:0] prod;
  logic [ACC_W:0]   sum_full;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_d;

  assign accept = in_valid & in_ready_q;

  mac_mult_stage #(
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk          (clk),
    .rst          (rst),
    .en_i         (accept),
    .a_i          (in_a),
    .b_i          (in_b),
    .prod_valid_o (prod_valid),
    .prod_o       (prod)
  );

  always_comb begin
    sum_full = {1'b0, acc_q} + {1'b0, prod};
    // Signed overflow: both addends share a sign the result does not.
    if (SIGNED != 0)
      add_ovf = (acc_q[ACC_W-1] == prod[ACC_W-1]) &&
                (sum_full[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = sum_full[ACC_W];
    acc_d = sum_full[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
    // A positive product can only cross the top bound, a negative one the bottom.
    if (add_ovf) begin
      if (SIGNED != 0) acc_d = prod[ACC_W-1] ? S_MIN : S_MAX;
      else             acc_d = U_MAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (prod_valid) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | add_ovf;
      end
      if (accept) cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        ST_ACCUM: begin
          if (accept && (in_last || cnt_q == LAST_CNT)) begin
            state_q    <= ST_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  // Parameters outside their legal ranges are not supported.
  if (SIGNED != 0) begin : g_s_used
  end
  logic unused_bounds;
  assign unused_bounds = ^{U_MAX, S_MAX, S_MIN};

endmodule

// File: tb/tb_mac_stream_accum.sv
// Testbench for mac_stream_accum: three instances (defaults, ACC_W=8,
// SIGNED=1) share one operand/result-ready stream.
module tb_mac_stream_accum;

`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [3:0] in_a, in_b;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [15:0] sum0, sum2;
  logic [7:0]  sum1;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        of0, of1, of2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_stream_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_sum(sum0), .out_count(cnt0), .out_ovf(of0));

  mac_stream_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_sum(sum1), .out_count(cnt1), .out_ovf(of1));

  mac_stream_accum #(.SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov2),
    .out_ready(out_ready), .out_sum(sum2), .out_count(cnt2), .out_ovf(of2));

  typedef struct {
    int         n;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_last;
    logic [15:0] e_sum;
    logic [7:0]  e_cnt;
    logic        e_ovf;
    logic [7:0]  e_sum8;
    logic        e_ovf8;
    logic [15:0] e_sum_s;
    logic        e_ovf_s;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n back-to-back beats, then checks the two-cycle result latency.
  // Returns with all instances in HOLD.
  task automatic run_frame(input int n, input logic [3:0] a, input logic [3:0] b,
                           input logic use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = use_last && (i == n - 1);
      chk("in_ready_beat", {29'd0, rdy0, rdy1, rdy2}, 32'h7);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_after_last", {29'd0, rdy0, rdy1, rdy2}, 32'h0);
    chk("out_valid_early", {29'd0, ov0, ov1, ov2}, 32'h0);
    step();
    chk("out_valid_rise", {29'd0, ov0, ov1, ov2}, 32'h7);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid", {29'd0, ov0, ov1, ov2}, 32'h0);
    chk("hs_in_ready", {29'd0, rdy0, rdy1, rdy2}, 32'h7);
    chk("hs_cleared", {sum0, cnt0, 7'd0, of0}, 32'h0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid"}, {30'd0, ov0, ov2}, 32'h0);
    chk({nm, "_ready"}, {30'd0, rdy0, rdy2}, 32'h3);
    chk({nm, "_sum"}, {sum0, sum2}, 32'h0);
    chk({nm, "_cnt_ovf"}, {cnt0, cnt1, 6'd0, of0, of1, sum1}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{128, 4'd15, 4'd15, 1'b0, 16'd28800, 8'd128, 1'b0,
                SAT ? 8'd255 : 8'd128, 1'b1, 16'd128, 1'b0};
    vecs[1] = '{3, 4'd3, 4'd5, 1'b1, 16'd45, 8'd3, 1'b0, 8'd45, 1'b0, 16'd45, 1'b0};
    vecs[2] = '{2, 4'd8, 4'd7, 1'b1, 16'd112, 8'd2, 1'b0, 8'd112, 1'b0, 16'hFF90, 1'b0};
    vecs[3] = '{1, 4'd2, 4'd2, 1'b1, 16'd4, 8'd1, 1'b0, 8'd4, 1'b0, 16'd4, 1'b0};
    vecs[4] = '{5, 4'd7, 4'd7, 1'b1, 16'd245, 8'd5, 1'b0, 8'd245, 1'b0, 16'd245, 1'b0};
    vecs[5] = '{6, 4'd7, 4'd7, 1'b1, 16'd294, 8'd6, 1'b0,
                SAT ? 8'd255 : 8'd38, 1'b1, 16'd294, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("reset");

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].n, vecs[v].a, vecs[v].b, vecs[v].use_last);
      chk($sformatf("v%0d_sum", v), {16'd0, sum0}, {16'd0, vecs[v].e_sum});
      chk($sformatf("v%0d_cnt", v), {cnt2, cnt1, cnt0},
          {vecs[v].e_cnt, vecs[v].e_cnt, vecs[v].e_cnt});
      chk($sformatf("v%0d_ovf", v), {29'd0, of0, of1, of2},
          {29'd0, vecs[v].e_ovf, vecs[v].e_ovf8, vecs[v].e_ovf_s});
      chk($sformatf("v%0d_sum8", v), {24'd0, sum1}, {24'd0, vecs[v].e_sum8});
      chk($sformatf("v%0d_sum_s", v), {16'd0, sum2}, {16'd0, vecs[v].e_sum_s});
      handshake();
    end

    // Long HOLD with back-pressure and stray input traffic.
    run_frame(3, 4'd3, 4'd5, 1'b1);
    in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", {30'd0, ov0, rdy0}, 32'h2);
      chk("hold_sum", {16'd0, sum0}, 32'd45);
      chk("hold_cnt", {24'd0, cnt0}, 32'd3);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
    run_frame(1, 4'd2, 4'd2, 1'b1);
    chk("after_hold_sum", {16'd0, sum0}, 32'd4);
    chk("after_hold_cnt", {24'd0, cnt0}, 32'd1);
    handshake();

    // out_ready high while accumulating must not matter; then reset mid-frame.
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1; in_last = 1'b0;
      step();
      chk("midframe_state", {30'd0, ov0, rdy0}, 32'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    chk("midframe_cnt", {24'd0, cnt0}, 32'd50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst_mid");
    run_frame(2, 4'd2, 4'd2, 1'b1);
    chk("post_rst_sum", {16'd0, sum0}, 32'd8);
    chk("post_rst_cnt", {24'd0, cnt0}, 32'd2);

    // Reset while a result is pending in HOLD.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst_hold");
    step();
    chk("rst_hold_stays", {29'd0, ov0, ov1, ov2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
